// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding and
// default sizing constants used by the top level and the bench.
package pwm_capture_pkg;

    // Default counter width and dead-line limit (100 MHz clock, 20 ms).
    localparam int CAPTURE_SIZE    = 21;
    localparam int CAPTURE_TIMEOUT = 2000000;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } captureState_t;

endpackage : pwm_capture_pkg

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer followed by a history register, producing the
// synchronized level and single-cycle rise/fall pulses. Reusable for any
// slow asynchronous digital input (encoder channels, IR, beacons).
module pwm_capture_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic dataIn,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync0;
    logic sync1;
    logic prev;

    // Synchronizer chain plus one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync0 <= dataIn;
            sync1 <= sync0;
            prev  <= sync1;
        end
    end

    // Edges are taken between the synchronized level and its history, so
    // rising and falling edges see identical delay.
    always_comb begin
        level = sync1;
        rise  = sync1 & ~prev;
        fall  = ~sync1 & prev;
    end

endmodule : pwm_capture_sync_edge

// File: rtl/pwm_capture.sv
// Pulse-train receiver: measures high time and rising-to-rising period of
// PulseIn in clk cycles, strobes Valid for each complete cycle and raises a
// sticky Timeout when no rising edge arrives within TIMEOUT cycles.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int SIZE    = CAPTURE_SIZE,
    parameter int TIMEOUT = CAPTURE_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PulseIn,
    output logic [SIZE-1:0] Width,
    output logic [SIZE-1:0] Period,
    output logic            Valid,
    output logic            Timeout,
    output logic            Level
);

    localparam logic [SIZE-1:0] CNT_ONE   = SIZE'(1);
    localparam logic [SIZE-1:0] CNT_LIMIT = SIZE'(TIMEOUT);

    logic rise;
    logic fall;

    // Current state is kept as a named signal so checkers can bind to it.
    captureState_t state;
    captureState_t stateNext;

    logic [SIZE-1:0] periodCnt;
    logic [SIZE-1:0] periodCntNext;
    logic [SIZE-1:0] highCnt;
    logic [SIZE-1:0] highCntNext;
    logic [SIZE-1:0] widthNext;
    logic [SIZE-1:0] periodNext;
    logic            validNext;
    logic            timeoutNext;
    logic            cntAtLimit;

    pwm_capture_sync_edge syncEdge (
        .clk    (clk),
        .reset  (reset),
        .dataIn (PulseIn),
        .level  (Level),
        .rise   (rise),
        .fall   (fall)
    );

    // The period counter is the only one that can reach the limit; the high
    // counter never runs ahead of it, so neither counter can wrap.
    assign cntAtLimit = (periodCnt == CNT_LIMIT);

    // State, counters and published outputs all update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            periodCnt <= '0;
            highCnt   <= '0;
            Width     <= '0;
            Period    <= '0;
            Valid     <= 1'b0;
            Timeout   <= 1'b0;
        end else begin
            state     <= stateNext;
            periodCnt <= periodCntNext;
            highCnt   <= highCntNext;
            Width     <= widthNext;
            Period    <= periodNext;
            Valid     <= validNext;
            Timeout   <= timeoutNext;
        end
    end

    // Next-state, counter and output decode. A rise in LOW takes priority
    // over the limit check so a period of exactly TIMEOUT still measures.
    always_comb begin
        stateNext     = state;
        periodCntNext = periodCnt;
        highCntNext   = highCnt;
        widthNext     = Width;
        periodNext    = Period;
        validNext     = 1'b0;
        timeoutNext   = Timeout;

        case (state)
            IDLE: begin
                // First edge only arms the measurement; nothing to publish.
                if (rise) begin
                    stateNext     = HIGH;
                    periodCntNext = CNT_ONE;
                    highCntNext   = CNT_ONE;
                end
            end

            HIGH: begin
                if (cntAtLimit) begin
                    stateNext     = IDLE;
                    periodCntNext = '0;
                    highCntNext   = '0;
                    timeoutNext   = 1'b1;
                end else begin
                    periodCntNext = periodCnt + CNT_ONE;
                    if (fall) begin
                        stateNext = LOW;
                    end else begin
                        highCntNext = highCnt + CNT_ONE;
                    end
                end
            end

            LOW: begin
                if (rise) begin
                    stateNext     = HIGH;
                    widthNext     = highCnt;
                    periodNext    = periodCnt;
                    validNext     = 1'b1;
                    timeoutNext   = 1'b0;
                    periodCntNext = CNT_ONE;
                    highCntNext   = CNT_ONE;
                end else if (cntAtLimit) begin
                    stateNext     = IDLE;
                    periodCntNext = '0;
                    highCntNext   = '0;
                    timeoutNext   = 1'b1;
                end else begin
                    periodCntNext = periodCnt + CNT_ONE;
                end
            end

            default: begin
                stateNext     = IDLE;
                periodCntNext = '0;
                highCntNext   = '0;
            end
        endcase
    end

endmodule : pwm_capture
